fp16_pool_reducer: RTL and testbench

//  Streaming multi-lane FP16 max/min pooling reducer for the CNN/U-Net datapath.

---
 rtl/fp16_pool_reducer.sv | 164 ++++++++++++++++
 tb/tb_fp16_pool_reducer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_pool_reducer.sv
// -----------------------------------------------------------------------------
// fp16_pool_reducer
//   Streaming multi-lane floating-point max/min pooling reducer. Each input beat
//   carries one element per lane. WINDOW consecutive accepted beats are reduced
//   per lane to the extreme element and the in-window beat index of that
//   element. The index drives max-unpooling in the decoder. Elements are ordered
//   by a sign-magnitude compare with no subtractor. +0 and -0 are equal. NaN and
//   Inf are ordered by their bit pattern.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear: drops the partial window; a pending result is kept
//   mode       0 = max, 1 = min; sampled on beat 0 of each window
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   in_data    LANES*DW bits; lane k at [k*DW +: DW]
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   out_data   per-lane extreme value, lane k at [k*DW +: DW]
//   out_idx    per-lane winning beat index, lane k at [k*IW +: IW]
// -----------------------------------------------------------------------------
module fp16_pool_reducer #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int LANES  = 4,
    parameter int WINDOW = 4,
    localparam int DW    = 1 + EXP_W + MAN_W,
    localparam int IW    = $clog2(WINDOW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [LANES*IW-1:0] out_idx
);

    // Returns 1 when a is strictly greater than b in sign-magnitude order.
    function automatic logic is_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-2:0] mag_a;
        logic [DW-2:0] mag_b;
        mag_a = a[DW-2:0];
        mag_b = b[DW-2:0];
        if ((mag_a == '0) && (mag_b == '0))
            return 1'b0;
        if (a[DW-1] != b[DW-1])
            return ~a[DW-1];
        if (!a[DW-1])
            return mag_a > mag_b;
        return mag_a < mag_b;
    endfunction

    logic [IW-1:0] cnt_reg;
    logic [IW-1:0] cnt_next;
    logic          mode_q_reg;
    logic          mode_q_next;
    logic          out_valid_reg;
    logic          out_valid_next;

    logic first_beat;
    logic last_beat;
    logic accept;

    assign first_beat = (cnt_reg == '0);
    assign last_beat  = (cnt_reg == IW'(WINDOW - 1));

    // Non-final beats never stall; the final beat waits only while a result is held.
    assign in_ready  = ~last_beat | ~out_valid_reg | out_ready;
    // clr wins over a same-cycle beat, which is dropped.
    assign accept    = in_valid & in_ready & ~clr;
    assign out_valid = out_valid_reg;

    always_comb begin
        cnt_next       = cnt_reg;
        mode_q_next    = mode_q_reg;
        out_valid_next = out_valid_reg;

        if (clr)
            cnt_next = '0;
        else if (accept)
            cnt_next = last_beat ? '0 : IW'(cnt_reg + 1'b1);

        if (accept && first_beat)
            mode_q_next = mode;

        // A final-beat load in the same cycle as a drain keeps out_valid high.
        if (accept && last_beat)
            out_valid_next = 1'b1;
        else if (out_ready)
            out_valid_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            mode_q_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            mode_q_reg    <= mode_q_next;
            out_valid_reg <= out_valid_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] lane_in;
            logic [DW-1:0] acc_reg;
            logic [DW-1:0] acc_next;
            logic [IW-1:0] idx_reg;
            logic [IW-1:0] idx_next;
            logic [DW-1:0] out_data_reg;
            logic [IW-1:0] out_idx_reg;
            logic          better;

            assign lane_in = in_data[gi*DW +: DW];
            // Strict compare so ties keep the earlier (lower index) element.
            assign better  = mode_q_reg ? is_gt(acc_reg, lane_in) : is_gt(lane_in, acc_reg);

            always_comb begin
                acc_next = acc_reg;
                idx_next = idx_reg;
                if (accept) begin
                    if (first_beat) begin
                        acc_next = lane_in;
                        idx_next = '0;
                    end else if (better) begin
                        acc_next = lane_in;
                        idx_next = cnt_reg;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg      <= '0;
                    idx_reg      <= '0;
                    out_data_reg <= '0;
                    out_idx_reg  <= '0;
                end else begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_next;
                    // WINDOW >= 2, so the final beat is never beat 0 and
                    // acc_next already folds in that beat.
                    if (accept && last_beat) begin
                        out_data_reg <= acc_next;
                        out_idx_reg  <= idx_next;
                    end
                end
            end

            assign out_data[gi*DW +: DW] = out_data_reg;
            assign out_idx[gi*IW +: IW]  = out_idx_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fp16_pool_reducer.sv
module tb_fp16_pool_reducer;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_idx;

    int checks;
    int failures;

    fp16_pool_reducer #(
        .EXP_W(5), .MAN_W(10), .LANES(4), .WINDOW(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [63:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Drive one beat from a negedge and return on the negedge after it is accepted.
    task automatic push(input logic [63:0] d, input logic m);
        int n;
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL push_timeout in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; in_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_idx !== 8'h0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h i=%h, required v=0 d=0 i=0", out_valid, out_data, out_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b, required 1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_max();
        // Mode 1 on beats 1..3 must be ignored (sampled only on beat 0).
        push(pk(16'h3C00, 16'h0000, 16'hC000, 16'h7C00), 1'b0);
        push(pk(16'h4000, 16'hBC00, 16'hC400, 16'h7BFF), 1'b1);
        push(pk(16'h3800, 16'h3C00, 16'hBC00, 16'h0000), 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL max_early_valid got %b, required 0", out_valid);
        end
        push(pk(16'h4000, 16'h3C00, 16'hC000, 16'h0000), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pk(16'h4000, 16'h3C00, 16'hBC00, 16'h7C00) || out_idx !== 8'h29) begin
            failures++;
            $display("FAIL max_result got v=%b d=%h i=%h, required v=1 d=%h i=29",
                     out_valid, out_data, out_idx, pk(16'h4000, 16'h3C00, 16'hBC00, 16'h7C00));
        end
        $display("test_max done d=%h i=%h", out_data, out_idx);
        @(negedge clk);
    endtask

    task automatic test_min_zero();
        push(pk(16'hC000, 16'h0000, 16'h3C00, 16'hFC00), 1'b1);
        push(pk(16'h3C00, 16'h8000, 16'h3800, 16'hFBFF), 1'b0);
        push(pk(16'h8000, 16'h0000, 16'h3800, 16'hFC00), 1'b0);
        push(pk(16'hC200, 16'h8000, 16'h4000, 16'h0000), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pk(16'hC200, 16'h0000, 16'h3800, 16'hFC00) || out_idx !== 8'h13) begin
            failures++;
            $display("FAIL min_result got v=%b d=%h i=%h, required v=1 d=%h i=13",
                     out_valid, out_data, out_idx, pk(16'hC200, 16'h0000, 16'h3800, 16'hFC00));
        end
        $display("test_min_zero done d=%h i=%h", out_data, out_idx);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(rep(16'h3C00), 1'b0);
        push(rep(16'h4000), 1'b0);
        push(rep(16'h4200), 1'b0);
        push(rep(16'h3800), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== rep(16'h4200) || out_idx !== 8'hAA) begin
            failures++;
            $display("FAIL bp_first got v=%b d=%h i=%h, required v=1 d=%h i=aa", out_valid, out_data, out_idx, rep(16'h4200));
        end
        push(rep(16'h4400), 1'b0);
        push(rep(16'h4000), 1'b0);
        push(rep(16'h3C00), 1'b0);
        in_data = rep(16'h4600);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall got in_ready=%b, required 0", in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== rep(16'h4200) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b, required v=1 d=%h rdy=0",
                         k, out_valid, out_data, in_ready, rep(16'h4200));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== rep(16'h4600) || out_idx !== 8'hFF) begin
            failures++;
            $display("FAIL bp_release got v=%b d=%h i=%h, required v=1 d=%h i=ff", out_valid, out_data, out_idx, rep(16'h4600));
        end
        $display("test_backpressure done d=%h i=%h", out_data, out_idx);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] w;
        out_ready = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            checks++;
            if (k >= 4 && (k % 4) == 0) begin
                w = 2'(k / 4 - 1);
                if (out_valid !== 1'b1 || out_data !== rep(16'h4000) || out_idx !== {w, w, w, w}) begin
                    failures++;
                    $display("FAIL b2b_result k=%0d got v=%b d=%h i=%h, required v=1 d=%h i=%h",
                             k, out_valid, out_data, out_idx, rep(16'h4000), {w, w, w, w});
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle k=%0d got v=%b, required 0", k, out_valid);
            end
            if (k < 12) begin
                in_data  = ((k % 4) == (k / 4)) ? rep(16'h4000) : rep(16'h3C00);
                mode     = 1'b0;
                in_valid = 1'b1;
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready k=%0d got %b, required 1", k, in_ready);
                end
                @(negedge clk);
            end else begin
                in_valid = 1'b0;
            end
        end
        $display("test_back_to_back done");
        @(negedge clk);
    endtask

    task automatic test_clr();
        push(rep(16'h7000), 1'b0);
        push(rep(16'h7400), 1'b0);
        clr = 1'b1;
        in_data = rep(16'h7800);
        in_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        push(rep(16'h3C00), 1'b0);
        push(rep(16'h3C00), 1'b0);
        push(rep(16'h3C00), 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_early_valid got %b, required 0", out_valid);
        end
        push(rep(16'h4400), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== rep(16'h4400) || out_idx !== 8'hFF) begin
            failures++;
            $display("FAIL clr_result got v=%b d=%h i=%h, required v=1 d=%h i=ff", out_valid, out_data, out_idx, rep(16'h4400));
        end
        $display("test_clr done d=%h i=%h", out_data, out_idx);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push(rep(16'h5000), 1'b0);
        push(rep(16'h5400), 1'b0);
        push(rep(16'h5800), 1'b0);
        push(rep(16'h5C00), 1'b0);
        push(rep(16'h6000), 1'b0);
        push(rep(16'h6400), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_idx !== 8'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b d=%h i=%h, required v=0 d=0 i=0", out_valid, out_data, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        push(rep(16'h4000), 1'b0);
        push(rep(16'h3C00), 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_early got v=%b, required 0", out_valid);
        end
        push(rep(16'h3800), 1'b0);
        push(rep(16'h4200), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== rep(16'h4200) || out_idx !== 8'hFF) begin
            failures++;
            $display("FAIL post_reset_result got v=%b d=%h i=%h, required v=1 d=%h i=ff", out_valid, out_data, out_idx, rep(16'h4200));
        end
        $display("test_async_reset done d=%h i=%h", out_data, out_idx);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_max();
        test_min_zero();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
